// File: rtl/btn_cond_pkg.sv
// Shared types and constants for the button conditioner.
// Optional auto-repeat is compiled in with BTN_COND_REPEAT_EN.
package btn_cond_pkg;

    localparam int unsigned SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    // Width of a counter that must hold values 0..max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/btn_chan.sv
// One button channel: two-flop synchroniser, debounce counter FSM, strobe/level outputs.
// BTN_COND_REPEAT_EN adds an auto-repeat strobe while the button stays held.
module btn_chan
    import btn_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned REPEAT_CYCLES   = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic strobe,
    output logic held
);

    localparam int unsigned        CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

`ifdef BTN_COND_REPEAT_EN
    localparam int unsigned        REP_W    = $clog2(REPEAT_CYCLES);
    localparam logic [REP_W-1:0]   REP_LAST = REP_W'(REPEAT_CYCLES - 1);
    localparam logic [REP_W-1:0]   REP_ONE  = REP_W'(1);
    logic [REP_W-1:0] rep_q;
`endif

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    btn_state_t             state_q;
    logic [CNT_W-1:0]       cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            strobe  <= 1'b0;
            held    <= 1'b0;
`ifdef BTN_COND_REPEAT_EN
            rep_q   <= '0;
`endif
        end else begin
            strobe <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (s) begin
                        state_q <= PRESS_WAIT;
                        cnt_q   <= CNT_ONE;
                    end else begin
                        cnt_q   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!s) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= HELD;
                        cnt_q   <= '0;
                        strobe  <= 1'b1;
                        held    <= 1'b1;
`ifdef BTN_COND_REPEAT_EN
                        rep_q   <= '0;
`endif
                    end else begin
                        cnt_q   <= cnt_q + CNT_ONE;
                    end
                end
                HELD: begin
                    if (!s) begin
                        state_q <= RELEASE_WAIT;
                        cnt_q   <= CNT_ONE;
                    end
`ifdef BTN_COND_REPEAT_EN
                    else if (rep_q == REP_LAST) begin
                        strobe  <= 1'b1;
                        rep_q   <= '0;
                    end else begin
                        rep_q   <= rep_q + REP_ONE;
                    end
`endif
                end
                RELEASE_WAIT: begin
                    // Repeat counter is frozen here so a release bounce resumes its period.
                    if (s) begin
                        state_q <= HELD;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        held    <= 1'b0;
`ifdef BTN_COND_REPEAT_EN
                        rep_q   <= '0;
`endif
                    end else begin
                        cnt_q   <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    held    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/btn_cond.sv
// Two-channel button conditioner feeding the a/b sequence detector.
// BTN_COND_REPEAT_EN enables auto-repeat strobes every REPEAT_CYCLES while held.
module btn_cond
    import btn_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned REPEAT_CYCLES   = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_a,
    input  logic raw_b,
    output logic a,
    output logic b,
    output logic a_held,
    output logic b_held
);

    btn_chan #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_chan_a (
        .clk    (clk),
        .rst    (rst),
        .raw    (raw_a),
        .strobe (a),
        .held   (a_held)
    );

    btn_chan #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_chan_b (
        .clk    (clk),
        .rst    (rst),
        .raw    (raw_b),
        .strobe (b),
        .held   (b_held)
    );

endmodule

// File: tb/tb_btn_cond.sv
// Directed self-checking bench for btn_cond with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8.
module tb_btn_cond;
    import btn_cond_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic raw_a;
    logic raw_b;
    logic a;
    logic b;
    logic a_held;
    logic b_held;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    btn_cond #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_CYCLES   (8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .raw_a  (raw_a),
        .raw_b  (raw_b),
        .a      (a),
        .b      (b),
        .a_held (a_held),
        .b_held (b_held)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst   = 1'b0;
        raw_a = 1'b0;
        raw_b = 1'b0;
        #1;
        chk("reset_a", 32'(a), 32'd0);
        chk("reset_b", 32'(b), 32'd0);
        chk("reset_ah", 32'(a_held), 32'd0);
        chk("reset_bh", 32'(b_held), 32'd0);
        step(2);
        rst = 1'b1;
        step(3);

        // Clean press on A: strobe after edge 5 only, level from edge 5.
        raw_a = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step(1);
            chk($sformatf("press_a_e%0d", k), 32'(a), 32'(k == 5));
            chk($sformatf("press_ah_e%0d", k), 32'(a_held), 32'(k >= 5));
            chk($sformatf("press_b_e%0d", k), 32'(b), 32'd0);
        end
        raw_a = 1'b0;
        step(12);
        chk("release_ah", 32'(a_held), 32'd0);

        // Two-cycle glitch is rejected.
        raw_a = 1'b1;
        step(2);
        raw_a = 1'b0;
        chk("glitch_a_e1", 32'(a), 32'd0);
        for (int k = 2; k < 10; k++) begin
            step(1);
            chk($sformatf("glitch_a_e%0d", k), 32'(a), 32'd0);
            chk($sformatf("glitch_ah_e%0d", k), 32'(a_held), 32'd0);
        end
        chk("glitch_state", 32'(dut.u_chan_a.state_q), 32'(IDLE));

        // Press, then release with one bounce: no second strobe.
        raw_a = 1'b1;
        step(6);
        chk("bounce_press_a", 32'(a), 32'd1);
        step(1);
        raw_a = 1'b0;
        for (int k = 0; k < 13; k++) begin
            step(1);
            if (k == 1) raw_a = 1'b1;
            if (k == 4) raw_a = 1'b0;
            chk($sformatf("bounce_a_e%0d", k), 32'(a), 32'd0);
            chk($sformatf("bounce_ah_e%0d", k), 32'(a_held), 32'(k < 10));
        end
        step(4);

        // Simultaneous presses strobe in the same cycle.
        raw_a = 1'b1;
        raw_b = 1'b1;
        step(5);
        chk("sim_a_e4", 32'(a), 32'd0);
        chk("sim_b_e4", 32'(b), 32'd0);
        step(1);
        chk("sim_a_e5", 32'(a), 32'd1);
        chk("sim_b_e5", 32'(b), 32'd1);
        chk("sim_ah_e5", 32'(a_held), 32'd1);
        chk("sim_bh_e5", 32'(b_held), 32'd1);
        step(1);
        chk("sim_a_e6", 32'(a), 32'd0);
        chk("sim_b_e6", 32'(b), 32'd0);
        raw_a = 1'b0;
        raw_b = 1'b0;
        step(12);

        // Asynchronous reset mid-debounce, button held through release.
        raw_b = 1'b1;
        step(7);
        chk("pre_rst_bh", 32'(b_held), 32'd1);
        raw_a = 1'b1;
        step(3);
        chk("pre_rst_state", 32'(dut.u_chan_a.state_q), 32'(PRESS_WAIT));
        raw_b = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_a", 32'(a), 32'd0);
        chk("async_rst_b", 32'(b), 32'd0);
        chk("async_rst_ah", 32'(a_held), 32'd0);
        chk("async_rst_bh", 32'(b_held), 32'd0);
        chk("async_rst_state", 32'(dut.u_chan_a.state_q), 32'(IDLE));
        step(1);
        rst = 1'b1;
        for (int k = 0; k < 7; k++) begin
            step(1);
            chk($sformatf("post_rst_a_e%0d", k), 32'(a), 32'(k == 5));
            chk($sformatf("post_rst_ah_e%0d", k), 32'(a_held), 32'(k >= 5));
        end
        raw_a = 1'b0;
        step(12);

        // Long hold on B: auto-repeat when enabled, single strobe otherwise.
        raw_b = 1'b1;
        for (int k = 0; k < 40; k++) begin
            step(1);
`ifdef BTN_COND_REPEAT_EN
            chk($sformatf("hold_b_e%0d", k), 32'(b), 32'(k >= 5 && ((k - 5) % 8) == 0));
`else
            chk($sformatf("hold_b_e%0d", k), 32'(b), 32'(k == 5));
`endif
        end
        raw_b = 1'b0;
        step(12);
        chk("final_bh", 32'(b_held), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
